zaxdma_lfsr_writer: RTL
=======================

// Module: zaxdma_lfsr_writer
// PURPOSE
//  AXI4 write-burst master that fills a memory region with the LFSR byte stream
//  the ZipDMA test checker expects; it is the source-buffer stage ahead of the DMA.
//  Per run: seed + bus-aligned start address + length in bus words; issues INCR
//  bursts with full strobes, counts responses, then reports done/error.
// PARAMETERS
//  ADDRESS_WIDTH  30  AXI address width (AW)
//  BUS_WIDTH      64  AXI data width (DW), power of 2, >=32
//  IW             1   AXI ID width; all IDs driven 0
//  LGMAXBURST     4   max burst = 2^LGMAXBURST beats (<=8)
//  LGLEN          20  width of length, in bus words
// PORTS
//  i_clk         in   1       clock
//  i_reset_n     in   1       asynchronous active-low reset
//  i_start       in   1       start run (ignored while o_busy)
//  i_seed        in   32      LFSR seed
//  i_addr        in   AW      start address; low log2(DW/8) bits ignored (treated 0)
//  i_len         in   LGLEN   run length in bus words
//  o_busy        out  1       run in progress
//  o_done        out  1       1-cycle pulse at run end
//  o_err         out  1       sticky: any BRESP!=OKAY this run
//  M_AXI_AW*     out  -       AWVALID/AWID/AWADDR/AWLEN[7:0]/AWSIZE/AWBURST; AWREADY in
//  M_AXI_W*      out  -       WVALID/WDATA[DW]/WSTRB[DW/8]/WLAST; WREADY in
//  M_AXI_B*      in   -       BVALID/BID/BRESP[2]; BREADY out (constant 1)
// BEHAVIOUR
//  Reset (async assert, sync release): AWVALID=WVALID=0, o_busy=o_done=o_err=0,
//   state IDLE, counters 0.
//  LFSR: 32b, POLY=32'hc000_0000; step: fb=^(s&POLY); s={s[30:0],fb}. Stream
//   byte = s[31:24], then 8 steps. Seed 0 yields all-zero data (legal).
//  Beat data: WDATA lane k (bits 8k+7:8k) = stream byte (beat*DW/8 + k); state
//   advances DW steps per accepted W beat only. WSTRB all ones.
//  Fixed fields: AWSIZE=log2(DW/8), AWBURST=INCR, AWLOCK/CACHE/PROT/QOS=0.
//  Burst length = min(remaining, 2^LGMAXBURST, words to next 4kB boundary);
//   AWLEN = length-1. Address advances length*(DW/8) per AW.
//  FSM: IDLE -i_start&len!=0-> RUN; IDLE -i_start&len==0-> o_done next cycle,
//   no AXI traffic. RUN -last AW accepted and last W beat accepted-> DRAIN;
//   DRAIN -outstanding B count==0-> IDLE with o_done pulse.
//  AW/W: next AWVALID raised only after the previous burst's AW accepted and its
//   WLAST accepted (at most one burst ahead on AW). W may lead AW by <=1 burst.
//   AWVALID/WVALID, once high, hold with stable payload until READY.
//  B: outstanding counter +1 on AW handshake, -1 on BVALID; both same cycle ->
//   unchanged. Width >= LGLEN+1. BRESP!=0 sets o_err; cleared on next accepted start.
//  o_busy=1 from cycle after accepted start through the o_done cycle.
//  Reset mid-run: all channels drop immediately; no completion pulse.
// STRUCTURE
//  Package zaxdma_pkg: LFSR POLY, width, advance function (shared with checker
//   so both sides agree), AXI BURST/RESP encodings.
//  Sub-module zaxdma_lfsr_bytes: seed load, DW-byte output, step-on-accept.
//  Top: FSM, AW address/length calc, W beat counter, B outstanding counter.
// TESTING
//  DW=64, addr 0x0000, len 4, seed 1 -> one AW AWLEN=3; 4 W beats, WLAST on
//   4th; data equals package-model stream; o_done 1 cycle after BVALID.
//  addr 0x0FC0, len 20, max16 -> AWs 0x0FC0 AWLEN=7, 0x1000 AWLEN=11; no 4kB cross.
//  len 0 -> no AWVALID/WVALID ever; o_done pulses once; o_busy stays 0.
//  Random AWREADY/WREADY/BVALID stalls, len 100 -> payload stable while stalled;
//   data identical to no-stall run; exactly 7 bursts, 7 B handshakes.
//  Second B returns SLVERR -> o_err=1 at done; next start clears it to 0.
//  Reset asserted mid-W-burst -> AWVALID/WVALID 0 same cycle; start after
//   release runs cleanly from new seed.

Source files
------------

// File: rtl/zaxdma_pkg.sv
// rtl/zaxdma_pkg.sv - shared LFSR stream model and AXI encodings for the ZipDMA LFSR writer
package zaxdma_pkg;

   localparam int                    LFSR_WIDTH = 32;
   localparam logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'hc000_0000;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } wr_state_t;

   // One Fibonacci step: feedback is the parity of the tapped bits, shifted in at bit 0
   function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
      return {s[LFSR_WIDTH-2:0], ^(s & LFSR_POLY)};
   endfunction

   // Advance n steps; the checker and the writer both use this so they agree on the stream
   function automatic logic [LFSR_WIDTH-1:0] lfsr_advance(input logic [LFSR_WIDTH-1:0] s,
                                                          input int unsigned n);
      logic [LFSR_WIDTH-1:0] r;
      r = s;
      for (int unsigned i = 0; i < n; i++) r = lfsr_step(r);
      return r;
   endfunction

endpackage

// File: rtl/zaxdma_lfsr_writer_if.sv
// rtl/zaxdma_lfsr_writer_if.sv - AXI4 write-only (AW/W/B) channel bundle
interface zaxdma_lfsr_writer_if #(
   parameter int AW = 30,
   parameter int DW = 64,
   parameter int IW = 1
);
   logic            awvalid;
   logic            awready;
   logic [IW-1:0]   awid;
   logic [AW-1:0]   awaddr;
   logic [7:0]      awlen;
   logic [2:0]      awsize;
   logic [1:0]      awburst;
   logic            awlock;
   logic [3:0]      awcache;
   logic [2:0]      awprot;
   logic [3:0]      awqos;

   logic            wvalid;
   logic            wready;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] wstrb;
   logic            wlast;

   logic            bvalid;
   logic            bready;
   logic [IW-1:0]   bid;
   logic [1:0]      bresp;

   modport master (
      output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      input  awready,
      output wvalid, wdata, wstrb, wlast,
      input  wready,
      input  bvalid, bid, bresp,
      output bready
   );

   modport slave (
      input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos,
      output awready,
      input  wvalid, wdata, wstrb, wlast,
      output wready,
      output bvalid, bid, bresp,
      input  bready
   );
endinterface

// File: rtl/zaxdma_lfsr_bytes.sv
// rtl/zaxdma_lfsr_bytes.sv - LFSR byte-stream generator presenting one bus word per step
module zaxdma_lfsr_bytes
   import zaxdma_pkg::*;
#(
   parameter int DW = 64
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_load,
   input  logic [LFSR_WIDTH-1:0] i_seed,
   input  logic                  i_step,
   output logic [DW-1:0]         o_data
);

   logic [LFSR_WIDTH-1:0] state;
   logic [LFSR_WIDTH-1:0] state_next;
   logic [LFSR_WIDTH-1:0] walk;

   // Unroll one beat of stream bytes; lane 0 carries the oldest byte
   always_comb begin
      walk   = state;
      o_data = '0;
      for (int k = 0; k < DW/8; k++) begin
         o_data[8*k +: 8] = walk[LFSR_WIDTH-1 -: 8];
         walk = lfsr_advance(walk, 8);
      end
      state_next = walk;
   end

   // Seed on run start, advance a full beat only when the beat is accepted
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n)  state <= '0;
      else if (i_load) state <= i_seed;
      else if (i_step) state <= state_next;
   end

endmodule

// File: rtl/zaxdma_lfsr_writer.sv
// rtl/zaxdma_lfsr_writer.sv - AXI4 burst writer filling a region with the LFSR test stream
module zaxdma_lfsr_writer
   import zaxdma_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 30,
   parameter int BUS_WIDTH     = 64,
   parameter int IW            = 1,
   parameter int LGMAXBURST    = 4,
   parameter int LGLEN         = 20
) (
   input  logic                     i_clk,
   input  logic                     i_reset_n,
   input  logic                     i_start,
   input  logic [31:0]              i_seed,
   input  logic [ADDRESS_WIDTH-1:0] i_addr,
   input  logic [LGLEN-1:0]         i_len,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_err,
   zaxdma_lfsr_writer_if.master     m_axi
);

   localparam int LGBYTES = $clog2(BUS_WIDTH/8);
   localparam int BLW     = LGMAXBURST + 1;
   localparam int LENW    = LGLEN + 1;
   localparam logic [LENW-1:0] MAX_BURST = LENW'(1) << LGMAXBURST;

   wr_state_t                state, state_next;
   logic [ADDRESS_WIDTH-1:0] aw_addr;
   logic [LGLEN-1:0]         remaining;
   logic [BLW-1:0]           burst_len;
   logic [BLW-1:0]           beats_left;
   logic                     awvalid_q, wvalid_q;
   logic [LENW-1:0]          outstanding;
   logic                     zero_done;
   logic                     err_q;
   logic [BUS_WIDTH-1:0]     beat_data;

   logic                     start_ok, aw_hs, w_hs, b_hs, slot_free, launch;
   logic [12:0]              to_4k_bytes, to_4k_words;
   logic [LENW-1:0]          cand;
   logic [BLW-1:0]           launch_len;
   logic                     unused_bits;

   assign start_ok  = (state == ST_IDLE) && i_start;
   assign aw_hs     = awvalid_q && m_axi.awready;
   assign w_hs      = wvalid_q && m_axi.wready;
   assign b_hs      = m_axi.bvalid;
   assign slot_free = !awvalid_q && !wvalid_q;
   assign launch    = (state == ST_RUN) && slot_free && (remaining != '0);

   assign to_4k_bytes = 13'h1000 - {1'b0, aw_addr[11:0]};
   assign to_4k_words = to_4k_bytes >> LGBYTES;
   assign unused_bits = ^{m_axi.bid, i_addr[LGBYTES-1:0]};

   // Burst length is the smallest of what is left, the burst cap and the room before 4kB
   always_comb begin
      cand = {1'b0, remaining};
      if (cand > MAX_BURST) cand = MAX_BURST;
      if (cand > LENW'(to_4k_words)) cand = LENW'(to_4k_words);
      launch_len = BLW'(cand);
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state <= ST_IDLE;
      else            state <= state_next;
   end

   // Next state: drain once every burst has been fully issued, finish when all B returned
   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (i_start && (i_len != '0)) state_next = ST_RUN;
         ST_RUN:   if ((remaining == '0) && slot_free) state_next = ST_DRAIN;
         ST_DRAIN: if (outstanding == '0) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Outputs: busy for the whole run including the done cycle; zero-length runs only pulse done
   always_comb begin
      o_busy = (state != ST_IDLE);
      o_done = ((state == ST_DRAIN) && (outstanding == '0)) || zero_done;
   end

   // Address channel: one burst in flight; address steps forward when the AW is taken
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         awvalid_q <= 1'b0;
         aw_addr   <= '0;
         remaining <= '0;
         burst_len <= '0;
      end else if (start_ok) begin
         aw_addr   <= {i_addr[ADDRESS_WIDTH-1:LGBYTES], {LGBYTES{1'b0}}};
         remaining <= i_len;
      end else if (launch) begin
         awvalid_q <= 1'b1;
         burst_len <= launch_len;
         remaining <= remaining - LGLEN'(launch_len);
      end else if (aw_hs) begin
         awvalid_q <= 1'b0;
         aw_addr   <= aw_addr + (ADDRESS_WIDTH'(burst_len) << LGBYTES);
      end
   end

   // Data channel: beat counter for the current burst, released alongside its AW
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wvalid_q   <= 1'b0;
         beats_left <= '0;
      end else if (launch) begin
         wvalid_q   <= 1'b1;
         beats_left <= launch_len;
      end else if (w_hs) begin
         beats_left <= beats_left - BLW'(1);
         if (beats_left == BLW'(1)) wvalid_q <= 1'b0;
      end
   end

   // Outstanding write responses; simultaneous issue and retire cancel out
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         outstanding <= '0;
      end else begin
         case ({aw_hs, b_hs})
            2'b10:   outstanding <= outstanding + LENW'(1);
            2'b01:   outstanding <= outstanding - LENW'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   // Sticky error for the run, plus the delayed done for zero-length starts
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         err_q     <= 1'b0;
         zero_done <= 1'b0;
      end else begin
         zero_done <= start_ok && (i_len == '0);
         if (start_ok)                                   err_q <= 1'b0;
         else if (b_hs && (m_axi.bresp != AXI_RESP_OKAY)) err_q <= 1'b1;
      end
   end

   assign o_err = err_q;

   zaxdma_lfsr_bytes #(.DW(BUS_WIDTH)) u_bytes (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (start_ok),
      .i_seed    (i_seed),
      .i_step    (w_hs),
      .o_data    (beat_data)
   );

   assign m_axi.awvalid = awvalid_q;
   assign m_axi.awid    = '0;
   assign m_axi.awaddr  = aw_addr;
   assign m_axi.awlen   = 8'(burst_len - BLW'(1));
   assign m_axi.awsize  = 3'(LGBYTES);
   assign m_axi.awburst = AXI_BURST_INCR;
   assign m_axi.awlock  = 1'b0;
   assign m_axi.awcache = 4'h0;
   assign m_axi.awprot  = 3'h0;
   assign m_axi.awqos   = 4'h0;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.wdata   = beat_data;
   assign m_axi.wstrb   = '1;
   assign m_axi.wlast   = (beats_left == BLW'(1));
   assign m_axi.bready  = 1'b1;

endmodule
